cb1_truth_checker: RTL and testbench
====================================

Name: cb1_truth_checker

Overview:
- Self-checking stimulus/response engine for the 3-input combinational block cb1 (inputs d, x, a; output l).
- Sweeps {d,x,a} from 3'b000 to 3'b111 and waits a programmable settle time per vector.
- Samples l, builds the observed 8-entry truth table, and compares it against an expected table.
- Replaces manual truth-table inspection with an on-chip or bench-embedded pass/fail checker.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before l is sampled; legal range 1..255.
- EXP_TABLE, 8'hE8, expected l per vector; bit i = expected l for {d,x,a} == i.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request one full sweep; accepted only in IDLE
- l  input  1  output of the block under test
- d  output  1  stimulus MSB (vector bit 2)
- x  output  1  stimulus bit 1
- a  output  1  stimulus LSB (vector bit 0)
- busy  output  1  high from the cycle after start is accepted through the last SAMPLE cycle
- done  output  1  one-cycle pulse when the sweep completes
- pass  output  1  1 when observed == EXP_TABLE; valid from the done pulse until the next accepted start
- observed  output  8  captured l per vector; bit i = l sampled for vector i
- err_count  output  4  number of mismatching vectors, 0..8

Behaviour:
- Reset: synchronous, active-high, one clock only. All outputs go to 0: d/x/a=0, busy=0, done=0, pass=0, observed=8'h00, err_count=0. State goes to IDLE, vector index=0, settle counter=0.
- Reset mid-sweep aborts immediately. No done pulse is issued, and partial results are discarded (cleared to 0).
- States:
  - IDLE: d/x/a=0, busy=0. If start=1, go to DRIVE with vec=0 and cnt=0, and clear observed, err_count and pass.
  - DRIVE: {d,x,a}=vec, busy=1. cnt increments each cycle. When cnt==SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: {d,x,a}=vec still held, busy=1.
    - observed[vec] <= l.
    - If l != EXP_TABLE[vec], err_count increments.
    - If vec==7, go to DONE. Otherwise vec <= vec+1, cnt <= 0, go to DRIVE.
  - DONE: done=1 for exactly this cycle, busy=0, {d,x,a}=0. pass <= (final err_count == 0), registered so it is valid in the DONE cycle. Next state is IDLE unconditionally.
- Timing:
  - Start accepted at edge E: first DRIVE cycle follows E.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done is high in cycle 8*(SETTLE_CYCLES+1)+1 counted from E (25 for the default).
- The stimulus vector changes only on DRIVE entry. It is stable for the whole DRIVE+SAMPLE window, with no glitches between vectors.
- l is sampled only in SAMPLE and ignored in all other states.
- The mismatch decision uses the same-cycle l and the registered vec. Including the vec==7 sample in err_count requires combinational next-count logic for the final pass evaluation.
- start is ignored while busy=1 and in the DONE cycle. A start held high continuously produces back-to-back sweeps: re-accepted in the IDLE cycle after DONE.
- observed, err_count and pass hold their values after DONE until the next accepted start or reset.
- err_count saturation is not needed: max 8 fits in 4 bits.
- cnt is wide enough for 255. SETTLE_CYCLES=1 gives a one-cycle DRIVE.

Test Plan:
- Default params, l driven by a majority model of {d,x,a}, pulse start → busy for 24 cycles, done in cycle 25, observed=8'hE8, err_count=0, pass=1.
- l tied to 0, start → observed=8'h00, err_count=4, pass=0. Tie l to 1 → observed=8'hFF, err_count=4, pass=0.
- l = inverted majority → observed=8'h17, err_count=8, pass=0.
- Monitor d/x/a during a sweep → sequence 000,001,…,111, each held exactly 3 cycles, then 000 in DONE/IDLE. Any mid-window change fails.
- start held high for 60 cycles → exactly two done pulses, 26 cycles apart. Results are cleared at the second accept and reproduced identically.
- Assert rst during vector 3's DRIVE → next cycle all outputs 0, state IDLE, no done pulse. A subsequent start completes a normal sweep with pass=1. Repeat with SETTLE_CYCLES=1 → done in cycle 17.

Source files
------------

// File: rtl/cb1_truth_checker.sv
// Stimulus/response checker for the 3-input block cb1: sweeps {d,x,a} through all
// eight vectors, samples l after a settle time, and compares against EXP_TABLE.
module cb1_truth_checker #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXP_TABLE     = 8'hE8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       l,
  output logic       d,
  output logic       x,
  output logic       a,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] observed,
  output logic [3:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_stateNext;
  logic [2:0] r_vec;
  logic [7:0] r_cnt;
  logic [7:0] r_observed;
  logic [3:0] r_errCount;
  logic       r_pass;
  logic       w_mismatch;
  logic [3:0] w_errNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:   if (start) w_stateNext = S_DRIVE;
      S_DRIVE:  if (r_cnt == LP_CNT_LAST) w_stateNext = S_SAMPLE;
      S_SAMPLE: w_stateNext = (r_vec == 3'd7) ? S_DONE : S_DRIVE;
      S_DONE:   w_stateNext = S_IDLE;
      default:  w_stateNext = S_IDLE;
    endcase
  end

  // The final sample must count toward pass in the same edge, hence the
  // combinational next error count.
  always_comb begin
    w_mismatch = (l != EXP_TABLE[r_vec]);
    w_errNext  = r_errCount + {3'b000, w_mismatch};
  end

  // r_vec drives the stimulus pins directly; it is held at 0 outside a sweep so
  // the pins come straight from flops and only change on DRIVE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec      <= 3'd0;
      r_cnt      <= 8'd0;
      r_observed <= 8'h00;
      r_errCount <= 4'd0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec      <= 3'd0;
            r_cnt      <= 8'd0;
            r_observed <= 8'h00;
            r_errCount <= 4'd0;
            r_pass     <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_cnt <= r_cnt + 8'd1;
        end
        S_SAMPLE: begin
          r_observed[r_vec] <= l;
          r_errCount        <= w_errNext;
          r_cnt             <= 8'd0;
          if (r_vec == 3'd7) begin
            r_vec  <= 3'd0;
            r_pass <= (w_errNext == 4'd0);
          end else begin
            r_vec <= r_vec + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign {d, x, a}  = r_vec;
  assign busy       = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
  assign done       = (r_state == S_DONE);
  assign pass       = r_pass;
  assign observed   = r_observed;
  assign err_count  = r_errCount;

endmodule

// File: tb/tb_cb1_truth_checker.sv
// Directed bench for cb1_truth_checker: a table of full sweeps with different
// l models, plus back-to-back, mid-sweep reset and SETTLE_CYCLES=1 sequences.
module tb_cb1_truth_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       startA, startB, lA, lB;
  logic       dA, xA, aA, busyA, doneA, passA;
  logic       dB, xB, aB, busyB, doneB, passB;
  logic [7:0] obsA, obsB;
  logic [3:0] errA, errB;

  int lMode [2];
  int vectors = 0;
  int miscompares = 0;

  logic [2:0] stimS [2];
  logic       busyS [2];
  logic       doneS [2];
  logic       passS [2];
  logic [7:0] obsS  [2];
  logic [3:0] errS  [2];

  cb1_truth_checker #(.SETTLE_CYCLES(2), .EXP_TABLE(8'hE8)) dutA (
    .clk(clk), .rst(rst), .start(startA), .l(lA),
    .d(dA), .x(xA), .a(aA), .busy(busyA), .done(doneA), .pass(passA),
    .observed(obsA), .err_count(errA)
  );

  cb1_truth_checker #(.SETTLE_CYCLES(1), .EXP_TABLE(8'hE8)) dutB (
    .clk(clk), .rst(rst), .start(startB), .l(lB),
    .d(dB), .x(xB), .a(aB), .busy(busyB), .done(doneB), .pass(passB),
    .observed(obsB), .err_count(errB)
  );

  // Modes: 0 majority, 1 tied low, 2 tied high, 3 inverted majority.
  function automatic logic lModel(int m, logic [2:0] v);
    logic maj;
    maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (m)
      0:       return maj;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return ~maj;
    endcase
  endfunction

  always_comb lA = lModel(lMode[0], {dA, xA, aA});
  always_comb lB = lModel(lMode[1], {dB, xB, aB});

  always_comb begin
    stimS[0] = {dA, xA, aA};  stimS[1] = {dB, xB, aB};
    busyS[0] = busyA;         busyS[1] = busyB;
    doneS[0] = doneA;         doneS[1] = doneB;
    passS[0] = passA;         passS[1] = passB;
    obsS[0]  = obsA;          obsS[1]  = obsB;
    errS[0]  = errA;          errS[1]  = errB;
  end

  typedef struct {
    int         mode;
    logic [7:0] expObs;
    logic [3:0] expErr;
    logic       expPass;
  } sweepVec_t;

  sweepVec_t sweepTable [4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic val);
    if (sel == 0) startA = val;
    else          startB = val;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulses start and follows the sweep until done, checking the stimulus
  // against the cycle number; returns at the negedge of the done cycle.
  task automatic runSweep(input int sel, input int settle, output int doneCyc,
                          output int busyCnt, output bit stimOk);
    doneCyc = 0;
    busyCnt = 0;
    stimOk  = 1'b1;
    @(negedge clk);
    applyStimulus(sel, 1'b1);
    @(negedge clk);
    applyStimulus(sel, 1'b0);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (busyS[sel]) begin
        busyCnt++;
        if (stimS[sel] !== 3'((cyc - 1) / (settle + 1))) stimOk = 1'b0;
      end else if (stimS[sel] !== 3'b000) begin
        stimOk = 1'b0;
      end
      if (doneS[sel]) begin
        doneCyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic checkAllZero(input int sel, input string tag);
    checkOutput({tag, ".busy"}, busyS[sel], 0);
    checkOutput({tag, ".done"}, doneS[sel], 0);
    checkOutput({tag, ".pass"}, passS[sel], 0);
    checkOutput({tag, ".stim"}, stimS[sel], 0);
    checkOutput({tag, ".observed"}, obsS[sel], 0);
    checkOutput({tag, ".err"}, errS[sel], 0);
  endtask

  task automatic midSweepReset(input int sel, input int settle);
    int  target, doneCyc, busyCnt;
    bit  stimOk, sawActive;
    lMode[sel] = 2;
    target = 3 * (settle + 1) + 1;
    @(negedge clk);
    applyStimulus(sel, 1'b1);
    @(negedge clk);
    applyStimulus(sel, 1'b0);
    for (int cyc = 1; cyc < target; cyc++) @(negedge clk);
    checkOutput("rstMid.stimVec3", stimS[sel], 3);
    checkOutput("rstMid.partialObs", obsS[sel], 8'h07);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkAllZero(sel, "rstMid");
    sawActive = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (doneS[sel] || busyS[sel]) sawActive = 1'b1;
    end
    checkOutput("rstMid.noDoneAfter", sawActive, 0);
    lMode[sel] = 0;
    runSweep(sel, settle, doneCyc, busyCnt, stimOk);
    checkOutput("afterRst.doneCycle", doneCyc, 8 * (settle + 1) + 1);
    checkOutput("afterRst.observed", obsS[sel], 8'hE8);
    checkOutput("afterRst.err", errS[sel], 0);
    checkOutput("afterRst.pass", passS[sel], 1);
  endtask

  initial begin
    int  doneCyc, busyCnt, pulses, first, second;
    bit  stimOk;
    logic [7:0] obsAtAccept, obsSecond;
    logic [3:0] errAtAccept, errSecond;
    logic       passSecond;

    sweepTable[0] = '{mode: 0, expObs: 8'hE8, expErr: 4'd0, expPass: 1'b1};
    sweepTable[1] = '{mode: 1, expObs: 8'h00, expErr: 4'd4, expPass: 1'b0};
    sweepTable[2] = '{mode: 2, expObs: 8'hFF, expErr: 4'd4, expPass: 1'b0};
    sweepTable[3] = '{mode: 3, expObs: 8'h17, expErr: 4'd8, expPass: 1'b0};

    rst = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    lMode[0] = 0;
    lMode[1] = 0;
    repeat (2) @(negedge clk);
    checkAllZero(0, "resetA");
    checkAllZero(1, "resetB");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      lMode[0] = sweepTable[i].mode;
      runSweep(0, 2, doneCyc, busyCnt, stimOk);
      checkOutput($sformatf("tbl%0d.doneCycle", i), doneCyc, 25);
      checkOutput($sformatf("tbl%0d.busyCycles", i), busyCnt, 24);
      checkOutput($sformatf("tbl%0d.stimSeq", i), stimOk, 1);
      checkOutput($sformatf("tbl%0d.observed", i), obsA, sweepTable[i].expObs);
      checkOutput($sformatf("tbl%0d.err", i), errA, sweepTable[i].expErr);
      checkOutput($sformatf("tbl%0d.pass", i), passA, sweepTable[i].expPass);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d.donePulseWidth", i), doneA, 0);
      checkOutput($sformatf("tbl%0d.idleStim", i), {dA, xA, aA}, 0);
      checkOutput($sformatf("tbl%0d.holdObs", i), obsA, sweepTable[i].expObs);
      checkOutput($sformatf("tbl%0d.holdPass", i), passA, sweepTable[i].expPass);
    end

    lMode[1] = 0;
    runSweep(1, 1, doneCyc, busyCnt, stimOk);
    checkOutput("settle1.doneCycle", doneCyc, 17);
    checkOutput("settle1.busyCycles", busyCnt, 16);
    checkOutput("settle1.stimSeq", stimOk, 1);
    checkOutput("settle1.observed", obsB, 8'hE8);
    checkOutput("settle1.pass", passB, 1);

    // start held high: second accept must clear the first sweep's results.
    lMode[0] = 2;
    pulses = 0;
    first = 0;
    second = 0;
    obsAtAccept = 8'hAA;
    errAtAccept = 4'hA;
    obsSecond = 8'h00;
    errSecond = 4'h0;
    passSecond = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b1);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (doneA) begin
        pulses++;
        if (pulses == 1) begin
          first = cyc;
        end else if (pulses == 2) begin
          second = cyc;
          obsSecond = obsA;
          errSecond = errA;
          passSecond = passA;
        end
      end
      if (pulses == 1 && cyc == first + 2) begin
        obsAtAccept = obsA;
        errAtAccept = errA;
      end
    end
    applyStimulus(0, 1'b0);
    checkOutput("b2b.pulseCount", pulses, 2);
    checkOutput("b2b.firstDone", first, 25);
    checkOutput("b2b.spacing", second - first, 26);
    checkOutput("b2b.clearedObs", obsAtAccept, 0);
    checkOutput("b2b.clearedErr", errAtAccept, 0);
    checkOutput("b2b.secondObs", obsSecond, 8'hFF);
    checkOutput("b2b.secondErr", errSecond, 4);
    checkOutput("b2b.secondPass", passSecond, 0);
    pulseReset();

    midSweepReset(0, 2);
    midSweepReset(1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
